pattern_writer: RTL and testbench
=================================

// Module: pattern_writer
// PURPOSE
//  Sequence generator/writer for the memory game: on start, produces LEVEL distinct nonzero
//  10-bit LED patterns from an LFSR, writes each into the 10-slot game number memory through
//  its write port (d/wn/we), and flashes each pattern on the LEDs for a hold time.
//  Once all patterns are shown, it zero-fills the unused slots and hands control to the player
//  phase via done. Sits between the game-control FSM and the number memory.
// PARAMETERS
//  HOLD_CYCLES  50_000_000  clk cycles each pattern is shown (>=1)
//  GAP_CYCLES   12_500_000  clk cycles of dark LEDs after each pattern (>=1)
//  SEED         10'h001     LFSR reset value; 0 is replaced by 10'h001
// PORTS
//  clk    in   1   clock
//  clrn   in   1   reset, asynchronous, active-low
//  start  in   1   begin a round; sampled only in IDLE
//  abort  in   1   synchronous cancel; return to IDLE
//  level  in   4   number of patterns; clamped: 0->1, >10->10; latched at start
//  d      out  10  write data to number memory
//  wn     out  4   write slot index, 0..9
//  we     out  1   write enable, one-cycle pulses
//  led    out  10  LED display
//  busy   out  1   high from the start edge until done
//  done   out  1   one-cycle pulse when the round is fully written
// BEHAVIOUR
//  Outputs: all registered. Reset values: d=0, wn=0, we=0, led=0, busy=0, done=0.
//   Reset also sets state=IDLE and lfsr=SEED.
//  LFSR: 10-bit Fibonacci, next={lfsr[8:0], lfsr[9]^lfsr[6]} (x^10+x^7+1, maximal, never 0).
//   Steps every cycle in IDLE, including the start cycle.
//   Steps once at each later SHOW entry; holds otherwise.
//   Pattern k is the lfsr value at its SHOW entry, so the patterns of a round are consecutive
//   LFSR states, distinct and nonzero.
//  States: IDLE, SHOW, GAP, FILL, DONE.
//  IDLE: led=0, we=0, busy=0.
//   On start & !abort: latch cnt=clamp(level); idx=0; enter SHOW.
//   At the entry edge: we=1, wn=0, d=lfsr, led=lfsr, busy=1.
//  SHOW: lasts HOLD_CYCLES cycles; led holds the pattern.
//   we is high only in the first SHOW cycle.
//   Then GAP.
//  GAP: lasts GAP_CYCLES cycles with led=0.
//   Then, if idx+1<cnt: idx++ and enter SHOW; the entry edge writes wn=idx, d=lfsr.
//   Otherwise: enter FILL, or DONE if cnt==10.
//  FILL: one cycle per slot wn=cnt..9, each with we=1, d=0, led=0.
//   This clears stale values from the previous round. Then DONE.
//  DONE: single cycle; done=1, we=0, busy=0. Then IDLE.
//  abort (any non-IDLE state): next edge goes to IDLE.
//   we=0, led=0, busy=0, done stays 0. Any writes already issued stand.
//   abort has priority over start.
//  start while busy: ignored; no restart.
//  clrn low mid-round: immediate return to reset values; any write in flight is dropped.
//  Write count per round: exactly 10 we pulses (cnt patterns + 10-cnt zero fills); wn never >9.
//  Counters: hold/gap counter wide enough for max(HOLD_CYCLES, GAP_CYCLES); idx and wn are 4 bits.
// TESTING
//  All cases use HOLD_CYCLES=4, GAP_CYCLES=2, SEED=10'h001, with start high on the first edge
//  after clrn is released.
//  1. level=3 -> patterns 001,002,004:
//     - we pulses at cycles 1, 7, 13 with wn=0,1,2
//     - led dark on cycles 5-6, 11-12, 17-18
//     - fill cycles 19-25 write wn=3..9 with d=0
//     - done=1 at cycle 26
//  2. level=10 -> patterns 001,002,004,008,010,020,040,081,102,204; no FILL; done one cycle after the last GAP.
//  3. level=0 -> one pattern (001), then 9 fills; level=15 -> behaves as 10.
//  4. abort at cycle 8 of a level=5 round -> IDLE at next edge; led=0, busy=0, no done.
//     The next start resumes from the current LFSR state.
//  5. start pulsed during SHOW/GAP -> ignored, sequence unchanged.
//     start held high through DONE -> a new round begins on the IDLE cycle.
//  6. clrn pulsed low during FILL -> all outputs 0 immediately; lfsr=001; no done.

Source files
------------

// File: rtl/pattern_writer.sv
// Memory-game sequence writer: shows LEVEL consecutive LFSR patterns on the LEDs,
// writes each into the number memory, zero-fills the remaining slots, then pulses done.
module pattern_writer #(
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter int         GAP_CYCLES  = 12_500_000,
    parameter logic [9:0] SEED        = 10'h001
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] level,
    output logic [9:0] d,
    output logic [3:0] wn,
    output logic       we,
    output logic [9:0] led,
    output logic       busy,
    output logic       done
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [9:0]    SEED_EFF  = (SEED == 10'h000) ? 10'h001 : SEED;

    typedef enum logic [2:0] {IDLE, SHOW, GAP, FILL, DONE} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [3:0]    idx, idx_n;
    logic [3:0]    cnt, cnt_n;
    logic [9:0]    lfsr, lfsr_n;
    logic [9:0]    d_n, led_n;
    logic [3:0]    wn_n;
    logic          we_n, busy_n, done_n;

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        return {v[8:0], v[9] ^ v[6]};
    endfunction

    function automatic logic [3:0] clamp_level(input logic [3:0] l);
        if (l == 4'd0)       return 4'd1;
        else if (l > 4'd10)  return 4'd10;
        else                 return l;
    endfunction

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            cnt   <= '0;
            lfsr  <= SEED_EFF;
            d     <= '0;
            wn    <= '0;
            we    <= 1'b0;
            led   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
            lfsr  <= lfsr_n;
            d     <= d_n;
            wn    <= wn_n;
            we    <= we_n;
            led   <= led_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        cnt_n   = cnt;
        lfsr_n  = lfsr;
        d_n     = d;
        wn_n    = wn;
        we_n    = 1'b0;
        led_n   = led;
        busy_n  = busy;
        done_n  = 1'b0;

        if (state != IDLE && abort) begin
            state_n = IDLE;
            led_n   = '0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    lfsr_n = lfsr_step(lfsr);
                    led_n  = '0;
                    busy_n = 1'b0;
                    if (start && !abort) begin
                        cnt_n   = clamp_level(level);
                        idx_n   = 4'd0;
                        timer_n = HOLD_LOAD;
                        state_n = SHOW;
                        we_n    = 1'b1;
                        wn_n    = 4'd0;
                        d_n     = lfsr;
                        led_n   = lfsr;
                        busy_n  = 1'b1;
                    end
                end
                SHOW: begin
                    if (timer == '0) begin
                        state_n = GAP;
                        timer_n = GAP_LOAD;
                        led_n   = '0;
                    end else begin
                        timer_n = timer - 1'b1;
                    end
                end
                GAP: begin
                    if (timer != '0) begin
                        timer_n = timer - 1'b1;
                    end else if (4'(idx + 4'd1) < cnt) begin
                        idx_n   = 4'(idx + 4'd1);
                        timer_n = HOLD_LOAD;
                        state_n = SHOW;
                        we_n    = 1'b1;
                        wn_n    = 4'(idx + 4'd1);
                        d_n     = lfsr;
                        led_n   = lfsr;
                        lfsr_n  = lfsr_step(lfsr);
                    end else if (cnt == 4'd10) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = FILL;
                        we_n    = 1'b1;
                        wn_n    = cnt;
                        d_n     = '0;
                    end
                end
                FILL: begin
                    if (wn == 4'd9) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                    end else begin
                        we_n = 1'b1;
                        wn_n = 4'(wn + 4'd1);
                        d_n  = '0;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_writer.sv
// Bench for pattern_writer: a timeline model predicts every output on every cycle,
// and directed rounds add hand-computed literal checks at key cycles.
module tb_pattern_writer;

    localparam int H = 4;
    localparam int G = 2;
    localparam int P = H + G;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] level = 4'd0;
    logic [9:0] d;
    logic [3:0] wn;
    logic       we;
    logic [9:0] led;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int cur = 0;
    bit cmp_en = 1'b0;

    pattern_writer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .SEED(10'h001)) dut (
        .clk(clk), .clrn(clrn), .start(start), .abort(abort), .level(level),
        .d(d), .wn(wn), .we(we), .led(led), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model: a round is a timeline of offsets t from its entry edge; patterns, fills
    // and the done pulse fall at fixed offsets derived from cnt, H and G.
    logic [9:0] m_lfsr;
    logic [9:0] pats [10];
    bit         active;
    int         t, m_cnt, len;
    logic [9:0] e_d, e_led;
    logic [3:0] e_wn;
    logic       e_we, e_busy, e_done;

    function automatic logic [9:0] poly_next(input logic [9:0] v);
        return ((v << 1) & 10'h3FF) | 10'(v[9] ^ v[6]);
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            active = 0; m_lfsr = 10'h001;
            e_d = 0; e_wn = 0; e_we = 0; e_led = 0; e_busy = 0; e_done = 0;
        end else begin
            if (!active) begin
                if (start && !abort) begin
                    active = 1; t = 0;
                    m_cnt = (level == 0) ? 1 : (level > 10) ? 10 : int'(level);
                    len = m_cnt * P + (10 - m_cnt);
                end else begin
                    m_lfsr = poly_next(m_lfsr);
                end
            end else if (abort) begin
                active = 0;
            end else begin
                t++;
                if (t > len) active = 0;
            end
            e_we = 0; e_done = 0;
            if (!active) begin
                e_led = 0; e_busy = 0;
            end else if (t < m_cnt * P) begin
                if (t % P == 0) begin
                    pats[t / P] = m_lfsr;
                    e_d = m_lfsr; e_wn = 4'(t / P); e_we = 1;
                    m_lfsr = poly_next(m_lfsr);
                end
                e_led = (t % P < H) ? pats[t / P] : 10'h000;
                e_busy = 1;
            end else if (t < len) begin
                e_wn = 4'(m_cnt + (t - m_cnt * P)); e_d = 0; e_we = 1;
                e_led = 0; e_busy = 1;
            end else begin
                e_done = 1; e_busy = 0; e_led = 0;
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cur, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("model_d", 32'(d), 32'(e_d));
            check_output("model_wn", 32'(wn), 32'(e_wn));
            check_output("model_we", 32'(we), 32'(e_we));
            check_output("model_led", 32'(led), 32'(e_led));
            check_output("model_busy", 32'(busy), 32'(e_busy));
            check_output("model_done", 32'(done), 32'(e_done));
        end
    end

    task automatic goto_cycle(input int c);
        while (cur < c) begin
            @(negedge clk);
            cur++;
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        #2 clrn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        cur = 0;
    endtask

    task automatic apply_stimulus(input logic [3:0] lv);
        reset_dut();
        level = lv;
        start = 1'b1;
        goto_cycle(1);
        start = 1'b0;
    endtask

    initial begin
        reset_dut();
        check_output("reset_busy", 32'(busy), 32'd0);
        check_output("reset_led", 32'(led), 32'd0);
        cmp_en = 1'b1;

        $display("[TB] level=3 round");
        level = 4'd3; start = 1'b1;
        goto_cycle(1); start = 1'b0;
        check_output("t1_c1_d", 32'(d), 32'h001);
        check_output("t1_c1_we", 32'(we), 32'd1);
        goto_cycle(5);  check_output("t1_c5_led", 32'(led), 32'h000);
        goto_cycle(7);  check_output("t1_c7_d", 32'(d), 32'h002);
        check_output("t1_c7_wn", 32'(wn), 32'd1);
        goto_cycle(13); check_output("t1_c13_d", 32'(d), 32'h004);
        goto_cycle(19); check_output("t1_c19_wn", 32'(wn), 32'd3);
        check_output("t1_c19_d", 32'(d), 32'h000);
        goto_cycle(25); check_output("t1_c25_wn", 32'(wn), 32'd9);
        goto_cycle(26); check_output("t1_c26_done", 32'(done), 32'd1);
        goto_cycle(28);

        $display("[TB] level=10 round");
        apply_stimulus(4'd10);
        goto_cycle(43); check_output("t2_c43_d", 32'(d), 32'h081);
        goto_cycle(55); check_output("t2_c55_d", 32'(d), 32'h204);
        check_output("t2_c55_wn", 32'(wn), 32'd9);
        goto_cycle(61); check_output("t2_c61_done", 32'(done), 32'd1);
        goto_cycle(63);

        $display("[TB] level=0 and level=15 clamps");
        apply_stimulus(4'd0);
        goto_cycle(7);  check_output("t3_c7_fill_wn", 32'(wn), 32'd1);
        goto_cycle(16); check_output("t3_c16_done", 32'(done), 32'd1);
        goto_cycle(18);
        apply_stimulus(4'd15);
        goto_cycle(61); check_output("t3_c61_done", 32'(done), 32'd1);
        goto_cycle(63);

        $display("[TB] abort mid-round");
        apply_stimulus(4'd5);
        goto_cycle(8); abort = 1'b1;
        goto_cycle(9); abort = 1'b0;
        check_output("t4_c9_busy", 32'(busy), 32'd0);
        check_output("t4_c9_d", 32'(d), 32'h002);
        start = 1'b1;
        goto_cycle(10); start = 1'b0;
        check_output("t4_c10_d", 32'(d), 32'h004);
        goto_cycle(45); check_output("t4_c45_done", 32'(done), 32'd1);
        goto_cycle(47);

        $display("[TB] start held through round");
        reset_dut();
        level = 4'd2; start = 1'b1;
        goto_cycle(21); check_output("t5_c21_done", 32'(done), 32'd1);
        goto_cycle(22); check_output("t5_c22_busy", 32'(busy), 32'd0);
        goto_cycle(23); start = 1'b0;
        check_output("t5_c23_we", 32'(we), 32'd1);
        check_output("t5_c23_d", 32'(d), 32'h004);
        goto_cycle(45);

        $display("[TB] reset during fill");
        apply_stimulus(4'd3);
        goto_cycle(21);
        #2 clrn = 1'b0;
        #1;
        check_output("t6_rst_we", 32'(we), 32'd0);
        check_output("t6_rst_wn", 32'(wn), 32'd0);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        clrn = 1'b1; cur = 0;
        level = 4'd3; start = 1'b1;
        goto_cycle(1); start = 1'b0;
        check_output("t6_c1_d", 32'(d), 32'h001);
        goto_cycle(28);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
